// File: rtl/id_ex_reader.sv
// id_ex_reader: EX-side consumer of the packed 134-bit ID/EX bundle.
// Bundles arrive over a valid/ready handshake and land in a 2-entry skid
// FIFO, so decode can run one cycle ahead of an EX stall. The head entry is
// unpacked into named fields. The block also derives the write-register index,
// the extended immediate and the branch target, and flags load-use hazards.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid/in_bundle/in_ready   upstream handshake (in_ready = count != 2)
//   out_valid/out_ready     head-valid / EX-consume handshake
//   flush                   discard every buffered entry at the next edge
//   id_rs, id_rt            source registers of the instruction in decode
//   reg_dst..alu_op         head control fields
//   pc_add, rs_data, rt_data, imm16, rt_idx, rd_idx   head data fields
//   wreg, imm32, br_target  derived head values
//   load_use                hazard request back to decode
module id_ex_reader #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned BW = 134,
  localparam int unsigned DW = 32,
  localparam int unsigned IW = 16,
  localparam int unsigned RW = 5,
  localparam int unsigned AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [BW-1:0] in_bundle,
  output logic          in_ready,
  input  logic          out_ready,
  input  logic          flush,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          out_valid,
  output logic          reg_dst,
  output logic          branch,
  output logic          mem_to_reg,
  output logic          mem_write,
  output logic          alu_src,
  output logic          reg_write,
  output logic          jump,
  output logic          ext_op,
  output logic [AW-1:0] alu_op,
  output logic [DW-1:0] pc_add,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [IW-1:0] imm16,
  output logic [RW-1:0] rt_idx,
  output logic [RW-1:0] rd_idx,
  output logic [RW-1:0] wreg,
  output logic [DW-1:0] imm32,
  output logic [DW-1:0] br_target,
  output logic          load_use
);

  localparam int unsigned CNT_W = 2;

  // Field view of one bundle, MSB first.
  typedef struct packed {
    logic          reg_dst;
    logic          branch;
    logic          mem_to_reg;
    logic [AW-1:0] alu_op;
    logic          mem_write;
    logic          alu_src;
    logic          reg_write;
    logic          jump;
    logic          ext_op;
    logic [DW-1:0] pc_add;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [IW-1:0] imm16;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
  } bundle_t;

  logic [BW-1:0]    mem [2];
  logic             rptr;
  logic             wptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  bundle_t          head;

  // Handshake status depends only on the registered count.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  // Flush cancels both the incoming push and any pending pop.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rptr   <= 1'b0;
      wptr   <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= in_bundle;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head unpack; fields show the stale entry while out_valid is low.
  assign head       = bundle_t'(mem[rptr]);
  assign reg_dst    = head.reg_dst;
  assign branch     = head.branch;
  assign mem_to_reg = head.mem_to_reg;
  assign alu_op     = head.alu_op;
  assign mem_write  = head.mem_write;
  assign alu_src    = head.alu_src;
  assign reg_write  = head.reg_write;
  assign jump       = head.jump;
  assign ext_op     = head.ext_op;
  assign pc_add     = head.pc_add;
  assign rs_data    = head.rs_data;
  assign rt_data    = head.rt_data;
  assign imm16      = head.imm16;
  assign rt_idx     = head.rt_idx;
  assign rd_idx     = head.rd_idx;

  // Derived values.
  assign wreg      = head.reg_dst ? head.rd_idx : head.rt_idx;
  assign imm32     = head.ext_op ? {{(DW-IW){head.imm16[IW-1]}}, head.imm16}
                                 : {{(DW-IW){1'b0}}, head.imm16};
  assign br_target = head.pc_add + {imm32[DW-3:0], 2'b00};

  // Register zero never carries a real dependency.
  assign load_use = out_valid & head.mem_to_reg & head.reg_write &
                    (wreg != '0) & ((wreg == id_rs) | (wreg == id_rt));

endmodule

// File: tb/tb_id_ex_reader.sv
// Directed bench for id_ex_reader: a queue scoreboard of accepted bundles
// mirrors the FIFO, and every cycle the head fields are checked against
// values decoded independently from the expected bundle.
module tb_id_ex_reader;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [133:0] in_bundle = '0;
  logic         in_ready;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [4:0]   id_rs = '0;
  logic [4:0]   id_rt = '0;
  logic         out_valid;
  logic         reg_dst, branch, mem_to_reg, mem_write, alu_src, reg_write, jump, ext_op;
  logic [3:0]   alu_op;
  logic [31:0]  pc_add, rs_data, rt_data;
  logic [15:0]  imm16;
  logic [4:0]   rt_idx, rd_idx, wreg;
  logic [31:0]  imm32, br_target;
  logic         load_use;

  int total = 0;
  int bad   = 0;

  logic [133:0] sb[$];
  int           mcount = 0;

  id_ex_reader dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_bundle(in_bundle), .in_ready(in_ready),
    .out_ready(out_ready), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .out_valid(out_valid),
    .reg_dst(reg_dst), .branch(branch), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .jump(jump), .ext_op(ext_op), .alu_op(alu_op),
    .pc_add(pc_add), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .wreg(wreg), .imm32(imm32), .br_target(br_target), .load_use(load_use)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ctl: RegDst Branch MemtoReg ALUOp[3:0] MemWrite ALUSrc RegWrite Jump Ext_op
  function automatic logic [133:0] mk(input logic [11:0] ctl, input logic [31:0] pc,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [15:0] i1, input logic [4:0] i2,
                                      input logic [4:0] i3);
    return {ctl, pc, rs, rt, i1, i2, i3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare handshake status, head fields and hazard against the scoreboard.
  task automatic check_all(input string tag);
    logic [133:0] b;
    logic [4:0]   w;
    logic [31:0]  x;
    logic         lu;
    chk({tag, ".in_ready"},  32'(in_ready),  32'(mcount != 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mcount != 0));
    lu = 1'b0;
    if (mcount != 0) begin
      b = sb[0];
      w = b[133] ? b[4:0] : b[9:5];
      x = b[122] ? {{16{b[25]}}, b[25:10]} : {16'h0000, b[25:10]};
      chk({tag, ".ctl"}, 32'({reg_dst, branch, mem_to_reg, alu_op, mem_write,
                              alu_src, reg_write, jump, ext_op}), 32'(b[133:122]));
      chk({tag, ".pc_add"},  pc_add,  b[121:90]);
      chk({tag, ".rs_data"}, rs_data, b[89:58]);
      chk({tag, ".rt_data"}, rt_data, b[57:26]);
      chk({tag, ".idx"}, 32'({imm16, rt_idx, rd_idx}), 32'(b[25:0]));
      chk({tag, ".wreg"},  32'(wreg), 32'(w));
      chk({tag, ".imm32"}, imm32, x);
      chk({tag, ".br_target"}, br_target, b[121:90] + (x << 2));
      lu = b[131] & b[124] & (w != 5'd0) & ((w == id_rs) | (w == id_rt));
    end
    chk({tag, ".load_use"}, 32'(load_use), 32'(lu));
  endtask

  // One clock: drive at negedge, check, advance model at posedge.
  task automatic cycle(input string tag, input logic v, input logic [133:0] b,
                       input logic r, input logic f);
    logic do_push, do_pop;
    in_valid = v; in_bundle = b; out_ready = r; flush = f;
    #1;
    check_all(tag);
    do_push = v && (mcount != 2) && !f;
    do_pop  = r && (mcount != 0) && !f;
    @(posedge clock);
    if (f) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(b);
    end
    mcount = sb.size();
    @(negedge clock);
  endtask

  logic [133:0] ba, bb, bc, bd, bh, bh2, zero;

  initial begin
    ba   = mk(12'h801, 32'h0000_1000, 32'h1111_1111, 32'h2222_2222, 16'hFFFF, 5'd3,  5'd9);
    bb   = mk(12'h548, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 16'h8000, 5'd17, 5'd2);
    bc   = mk(12'h077, 32'h0000_4000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 16'h7FF0, 5'd1,  5'd30);
    bd   = mk(12'hFFF, 32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0002, 16'h1234, 5'd6,  5'd12);
    bh   = mk(12'h204, 32'h0000_2000, 32'h0000_0001, 32'h0000_0002, 16'h0004, 5'd4,  5'd7);
    bh2  = mk(12'h204, 32'h0000_3000, 32'h0000_0003, 32'h0000_0004, 16'h0008, 5'd0,  5'd4);
    zero = '0;

    // Reset state.
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.load_use",  32'(load_use),  32'd0);
    chk("rst.wreg",      32'(wreg),      32'd0);
    chk("rst.imm32",     imm32,          32'd0);
    chk("rst.br_target", br_target,      32'd0);
    @(negedge clock);

    // Single push: field decode with sign extension and negative offset.
    cycle("t1.push", 1'b1, ba, 1'b0, 1'b0);
    chk("t1.out_valid", 32'(out_valid), 32'd1);
    chk("t1.wreg",      32'(wreg),      32'd9);
    chk("t1.imm32",     imm32,          32'hFFFF_FFFF);
    chk("t1.br_target", br_target,      32'h0000_0FFC);
    cycle("t1.pop", 1'b0, zero, 1'b1, 1'b0);

    // Stalled EX: A, B accepted, C held; then drain in order.
    cycle("t2.a", 1'b1, ba, 1'b0, 1'b0);
    cycle("t2.b", 1'b1, bb, 1'b0, 1'b0);
    #1 chk("t2.full.in_ready", 32'(in_ready), 32'd0);
    cycle("t2.c_held", 1'b1, bc, 1'b0, 1'b0);
    cycle("t2.pop_a", 1'b1, bc, 1'b1, 1'b0);
    cycle("t2.pop_b_push_c", 1'b1, bc, 1'b1, 1'b0);
    chk("t2.head_c.rd_idx", 32'(rd_idx), 32'd30);
    cycle("t2.pop_c", 1'b0, zero, 1'b1, 1'b0);

    // Count 1: simultaneous push/pop keeps count, head becomes pushed bundle.
    cycle("t3.fill", 1'b1, bd, 1'b0, 1'b0);
    cycle("t3.pushpop", 1'b1, bb, 1'b1, 1'b0);
    chk("t3.out_valid", 32'(out_valid), 32'd1);
    chk("t3.pc_add",    pc_add,         32'hFFFF_FFF0);
    chk("t3.br_wrap",   br_target,      32'h0001_FFF0);
    cycle("t3.pushpop2", 1'b1, bc, 1'b1, 1'b0);
    cycle("t3.drain", 1'b0, zero, 1'b1, 1'b0);

    // Flush at count 2 drops everything including the incoming bundle.
    cycle("t4.d", 1'b1, bd, 1'b0, 1'b0);
    cycle("t4.a", 1'b1, ba, 1'b0, 1'b0);
    cycle("t4.flush", 1'b1, bc, 1'b1, 1'b1);
    #1;
    chk("t4.out_valid", 32'(out_valid), 32'd0);
    chk("t4.in_ready",  32'(in_ready),  32'd1);
    cycle("t4.idle", 1'b0, zero, 1'b0, 1'b0);

    // Load-use hazard.
    cycle("t5.push_h", 1'b1, bh, 1'b0, 1'b0);
    in_valid = 1'b0;
    id_rs = 5'd0; id_rt = 5'd4;
    #1 chk("t5.rt_match", 32'(load_use), 32'd1);
    id_rs = 5'd4; id_rt = 5'd0;
    #1 chk("t5.rs_match", 32'(load_use), 32'd1);
    id_rs = 5'd5; id_rt = 5'd5;
    #1 chk("t5.no_match", 32'(load_use), 32'd0);
    @(negedge clock);
    cycle("t5.pop_h", 1'b0, zero, 1'b1, 1'b0);
    id_rs = 5'd0; id_rt = 5'd0;
    cycle("t5.push_h2", 1'b1, bh2, 1'b0, 1'b0);
    #1 chk("t5.r0", 32'(load_use), 32'd0);
    cycle("t5.pop_h2", 1'b0, zero, 1'b1, 1'b0);

    // Asynchronous reset between edges with count 2.
    cycle("t6.a", 1'b1, ba, 1'b0, 1'b0);
    cycle("t6.b", 1'b1, bb, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6.out_valid", 32'(out_valid), 32'd0);
    chk("t6.in_ready",  32'(in_ready),  32'd1);
    chk("t6.br_target", br_target,      32'd0);
    sb.delete();
    mcount = 0;
    @(negedge clock);
    reset = 1'b0;
    cycle("t6.recover", 1'b1, bc, 1'b0, 1'b0);
    cycle("t6.drain", 1'b0, zero, 1'b1, 1'b0);
    cycle("t6.idle", 1'b0, zero, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
